// File: rtl/pipeline_pause_ctrl.sv
// Central stall generator for the 5-stage pipeline: merges load-use, mul/div and
// MEM wait-state requests into a prefix-form per-stage pause vector.
module pipeline_pause_ctrl #(
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_load_use,
    input  logic              ex_muldiv_start,
    input  logic              ex_is_div,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [4:0]        pause,
    output logic              muldiv_done,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_n;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;
    logic [PERF_W-1:0]   r_stall_cycles;
    logic                w_mem_wait;
    logic                w_ex_req;
    logic                w_done;
    logic [4:0]          w_pause;

    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_n        = ex_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ex_req    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_muldiv_start) begin
                    w_ex_req = 1'b1;
                    if (w_n == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = w_n - CNT_W'(1);
                    end
                end
            end
            S_BUSY: begin
                w_ex_req  = 1'b1;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // The finished op is still in EX; hold done until MEM lets it advance.
                w_done = 1'b1;
                if (!w_mem_wait) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_pause = 5'b00000;
        if (!rst) begin
            if (w_mem_wait)       w_pause = 5'b01111;
            else if (w_ex_req)    w_pause = 5'b00111;
            else if (id_load_use) w_pause = 5'b00011;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!w_mem_wait)                            r_wait_cnt <= '0;
            else if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) r_mem_timeout <= 1'b1;
            if (w_pause[0]) r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign pause        = w_pause;
    assign muldiv_done  = w_done & ~rst;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_pause_ctrl.sv
// Self-checking bench for pipeline_pause_ctrl: per-cycle expected pause/done pushed
// to a scoreboard queue as stimulus is driven, popped and compared mid-cycle.
module tb_pipeline_pause_ctrl;

    localparam int MEM_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_load_use, ex_muldiv_start, ex_is_div, mem_req, mem_ready;
    logic [4:0]  pause;
    logic        muldiv_done, mem_timeout;
    logic [31:0] stall_cycles;

    typedef struct {
        string      tag;
        logic [4:0] p;
        logic       d;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_pause_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .PERF_W     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_load_use    (id_load_use),
        .ex_muldiv_start(ex_muldiv_start),
        .ex_is_div      (ex_is_div),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pause          (pause),
        .muldiv_done    (muldiv_done),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        else             n_pass++;
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic cyc(input logic r, input logic lu, input logic st, input logic dv,
                       input logic mr, input logic mrd, input logic [4:0] ep,
                       input logic ed, input string tag);
        exp_t e;
        rst = r; id_load_use = lu; ex_muldiv_start = st; ex_is_div = dv;
        mem_req = mr; mem_ready = mrd;
        e.tag = tag; e.p = ep; e.d = ed;
        sb.push_back(e);
        if (r) exp_stall = 0;
        else   exp_stall += int'(ep[0]);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".pause"}, 32'(pause), 32'(e.p));
        check({e.tag, ".done"},  32'(muldiv_done), 32'(e.d));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 5'b00000, 0, tag);
    endtask

    task automatic mul_op(input string tag);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 5'b00111, 0, {tag, "_busy"});
        cyc(0, 0, 1, 0, 0, 0, 5'b00000, 1, {tag, "_done"});
    endtask

    initial begin
        rst = 1'b1; id_load_use = 0; ex_muldiv_start = 0; ex_is_div = 0;
        mem_req = 0; mem_ready = 0;
        #1;
        // Reset ignores active requests.
        cyc(1, 1, 1, 0, 1, 0, 5'b00000, 0, "rst0");
        cyc(1, 1, 0, 0, 1, 0, 5'b00000, 0, "rst1");
        check("rst_stall", stall_cycles, 32'(exp_stall));
        check("rst_timeout", 32'(mem_timeout), 32'd0);

        // Single load-use bubble.
        cyc(0, 1, 0, 0, 0, 0, 5'b00011, 0, "lu");
        idle("lu_after");
        check("lu_stall", stall_cycles, 32'(exp_stall));

        // Multiply, then a back-to-back multiply seen in IDLE.
        mul_op("mul");
        mul_op("mul_b2b");
        idle("mul_idle");
        check("mul_stall", stall_cycles, 32'(exp_stall));

        // Load-use during mul BUSY must keep the prefix at stage 2.
        cyc(0, 0, 1, 0, 0, 0, 5'b00111, 0, "lu_mul0");
        cyc(0, 1, 1, 0, 0, 0, 5'b00111, 0, "lu_mul1");
        cyc(0, 1, 1, 0, 0, 0, 5'b00111, 0, "lu_mul2");
        cyc(0, 0, 1, 0, 0, 0, 5'b00111, 0, "lu_mul3");
        cyc(0, 0, 1, 0, 0, 0, 5'b00000, 1, "lu_mul_done");
        idle("lu_mul_idle");

        // Divide overlapping a MEM wait from T+31 to T+34.
        for (int i = 0; i < 31; i++) cyc(0, 0, 1, 1, 0, 0, 5'b00111, 0, "div_busy");
        cyc(0, 0, 1, 1, 1, 0, 5'b01111, 0, "div_last_mw");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 5'b01111, 1, "div_done_hold");
        cyc(0, 0, 1, 1, 0, 0, 5'b00000, 1, "div_done_rel");
        idle("div_idle");
        check("div_stall", stall_cycles, 32'(exp_stall));
        check("div_no_timeout", 32'(mem_timeout), 32'd0);

        // MEM timeout: sticky after the wait ends, cleared only by reset.
        for (int i = 1; i <= MEM_TIMEOUT + 2; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 5'b01111, 0, "mw");
            if (i == MEM_TIMEOUT - 1) check("timeout_early", 32'(mem_timeout), 32'd0);
        end
        cyc(0, 0, 0, 0, 1, 1, 5'b00000, 0, "mw_ready");
        check("timeout_set", 32'(mem_timeout), 32'd1);
        idle("mw_idle");
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        check("mw_stall", stall_cycles, 32'(exp_stall));
        cyc(1, 0, 0, 0, 0, 0, 5'b00000, 0, "rst_to");
        check("timeout_clr", 32'(mem_timeout), 32'd0);
        check("rst_to_stall", stall_cycles, 32'd0);

        // Reset mid-divide (cnt=10), then a clean multiply.
        for (int i = 0; i < 22; i++) cyc(0, 0, 1, 1, 0, 0, 5'b00111, 0, "div2_busy");
        cyc(1, 0, 1, 1, 0, 0, 5'b00000, 0, "div2_rst");
        check("div2_rst_stall", stall_cycles, 32'd0);
        mul_op("mul_post_rst");
        idle("mul_post_rst_idle");
        check("post_rst_stall", stall_cycles, 32'(exp_stall));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
